// File: rtl/counter_shift_reg.sv
// counter_shift_reg: general-purpose state register for counter, timer and
// serializer datapaths. Supports parallel load (clamped to MAX), modulo
// up/down counting with wrap or saturate, and shift/rotate in both directions.
// A clock enable gates all updates except the wrap pulse, which always clears.

module counter_shift_reg #(
    parameter int LEN = 8,
    parameter int MAX = 2**LEN - 1
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           clr_s,
    input  logic           clk_enable,
    input  logic [2:0]     op,
    input  logic           sat,
    input  logic [LEN-1:0] data,
    input  logic           sin,
    output logic [LEN-1:0] q,
    output logic           wrap,
    output logic           sout,
    output logic           zero,
    output logic           at_max
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_UP   = 3'b010;
    localparam logic [2:0] OP_DOWN = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_ROR  = 3'b111;

    localparam logic [LEN-1:0] MAX_Q = LEN'(MAX);
    // Limit compares run one bit wider so q above MAX (left behind by a
    // shift or rotate) is still ordered correctly against the limit.
    localparam logic [LEN:0]   MAX_W = {1'b0, MAX_Q};

    logic [LEN-1:0] q_next;
    logic           wrap_next;
    logic           sout_next;
    logic [LEN:0]   q_ext;
    logic [LEN:0]   data_ext;

    assign q_ext    = {1'b0, q};
    assign data_ext = {1'b0, data};

    // Next-state selection: synchronous clear first, then the op decode.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        sout_next = sout;
        if (!clr_s) begin
            q_next = '0;
        end else begin
            case (op)
                OP_HOLD: q_next = q;
                OP_LOAD: q_next = (data_ext > MAX_W) ? MAX_Q : data;
                OP_UP: begin
                    if (q_ext >= MAX_W) begin
                        if (sat) begin
                            q_next = MAX_Q;
                        end else begin
                            q_next    = '0;
                            wrap_next = 1'b1;
                        end
                    end else begin
                        q_next = q + LEN'(1);
                    end
                end
                OP_DOWN: begin
                    if (q == '0) begin
                        if (sat) begin
                            q_next = '0;
                        end else begin
                            q_next    = MAX_Q;
                            wrap_next = 1'b1;
                        end
                    end else if (q_ext > MAX_W) begin
                        q_next = MAX_Q;
                    end else begin
                        q_next = q - LEN'(1);
                    end
                end
                OP_SHL: begin
                    q_next    = {q[LEN-2:0], sin};
                    sout_next = q[LEN-1];
                end
                OP_SHR: begin
                    q_next    = {sin, q[LEN-1:1]};
                    sout_next = q[0];
                end
                OP_ROL: begin
                    q_next    = {q[LEN-2:0], q[LEN-1]};
                    sout_next = q[LEN-1];
                end
                OP_ROR: begin
                    q_next    = {q[0], q[LEN-1:1]};
                    sout_next = q[0];
                end
                default: q_next = q;
            endcase
        end
    end

    // State registers; wrap is a one-cycle pulse so it clears even when disabled.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q    <= '0;
            wrap <= 1'b0;
            sout <= 1'b0;
        end else if (clk_enable) begin
            q    <= q_next;
            wrap <= wrap_next;
            sout <= sout_next;
        end else begin
            wrap <= 1'b0;
        end
    end

    assign zero   = (q == '0);
    assign at_max = (q == MAX_Q);

endmodule
